// File: rtl/pc_sequencer_if.sv
// Control-unit side of the program sequencer: instruction command fields in,
// program counter back out to the program memory.
interface pc_sequencer_if #(
    parameter int PC_W = 16
);
    logic [2:0]      cmd;
    logic [PC_W-1:0] target;
    logic            cond;
    logic [PC_W-1:0] pc;

    modport master (output cmd, output target, output cond, input pc);
    modport slave  (input cmd, input target, input cond, output pc);
endinterface

// File: rtl/pc_sequencer.sv
// Single-clock program sequencer: tick divider, PC register, return stack and
// operator/display wait states. Instruction-level state moves only on tick.
module pc_sequencer #(
    parameter int PC_W  = 16,
    parameter int SW_W  = 16,
    parameter int DEPTH = 16,
    parameter int DIV   = 12500000
) (
    input  logic                     clk0,
    input  logic                     reset,
    pc_sequencer_if.slave            bus,
    input  logic                     ent,
    input  logic [SW_W-1:0]          switch,
    input  logic                     dl,
    output logic                     tick,
    output logic [SW_W-1:0]          r_switch,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     ovf,
    output logic                     unf,
    output logic                     halted
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [AW:0]      SP_FULL  = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        CMD_NEXT    = 3'd0,
        CMD_JMP     = 3'd1,
        CMD_BR      = 3'd2,
        CMD_CALL    = 3'd3,
        CMD_RET     = 3'd4,
        CMD_WAIT_IN = 3'd5,
        CMD_WAIT_DL = 3'd6,
        CMD_HALT    = 3'd7
    } cmd_e;

    typedef enum logic {ST_RUN, ST_STOP} state_e;

    state_e            state_q, state_n;
    logic [CNT_W-1:0]  div_cnt, div_nxt;
    logic [PC_W-1:0]   pc_q, pc_n, pc_inc;
    logic [AW:0]       sp_n;
    logic [AW-1:0]     rd_idx;
    logic              ovf_n, unf_n, arm, arm_n, pend, pend_n, push;
    logic [SW_W-1:0]   rsw_n;
    logic              ent_s1, ent_s2, ent_d, release_edge;
    logic [PC_W-1:0]   stack [DEPTH];

    assign pc_inc       = pc_q + 1'b1;
    assign rd_idx       = AW'(sp - 1'b1);
    assign release_edge = ent_s2 & ~ent_d;
    assign halted       = (state_q == ST_STOP);
    assign bus.pc       = pc_q;
    assign div_nxt      = (div_cnt == CNT_LAST) ? '0 : div_cnt + 1'b1;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        sp_n    = sp;
        ovf_n   = ovf;
        unf_n   = unf;
        rsw_n   = r_switch;
        arm_n   = arm;
        pend_n  = pend;
        push    = 1'b0;
        if (state_q == ST_RUN) begin
            if (release_edge && bus.cmd == CMD_WAIT_IN) pend_n = 1'b1;
            if (tick) begin
                if (bus.cmd != CMD_WAIT_IN) pend_n = 1'b0;
                if (bus.cmd != CMD_WAIT_DL) arm_n  = 1'b0;
                case (bus.cmd)
                    CMD_NEXT: pc_n = pc_inc;
                    CMD_JMP:  pc_n = bus.target;
                    CMD_BR:   pc_n = bus.cond ? bus.target : pc_inc;
                    CMD_CALL:
                        if (sp == SP_FULL) begin
                            ovf_n   = 1'b1;
                            state_n = ST_STOP;
                        end else begin
                            push = 1'b1;
                            sp_n = sp + 1'b1;
                            pc_n = bus.target;
                        end
                    CMD_RET:
                        if (sp == '0) begin
                            unf_n   = 1'b1;
                            state_n = ST_STOP;
                        end else begin
                            pc_n = stack[rd_idx];
                            sp_n = sp - 1'b1;
                        end
                    // A release seen in this very cycle survives for the next tick.
                    CMD_WAIT_IN:
                        if (pend) begin
                            rsw_n  = switch;
                            pc_n   = pc_inc;
                            pend_n = release_edge;
                        end
                    CMD_WAIT_DL:
                        if (!arm) begin
                            arm_n = 1'b1;
                        end else if (!dl) begin
                            pc_n  = pc_inc;
                            arm_n = 1'b0;
                        end
                    CMD_HALT: state_n = ST_STOP;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            tick     <= 1'b0;
            ent_s1   <= 1'b1;
            ent_s2   <= 1'b1;
            ent_d    <= 1'b1;
            state_q  <= ST_RUN;
            pc_q     <= '0;
            sp       <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            r_switch <= '0;
            arm      <= 1'b0;
            pend     <= 1'b0;
        end else begin
            div_cnt  <= div_nxt;
            tick     <= (div_nxt == CNT_LAST);
            ent_s1   <= ent;
            ent_s2   <= ent_s1;
            ent_d    <= ent_s2;
            state_q  <= state_n;
            pc_q     <= pc_n;
            sp       <= sp_n;
            ovf      <= ovf_n;
            unf      <= unf_n;
            r_switch <= rsw_n;
            arm      <= arm_n;
            pend     <= pend_n;
        end
    end

    // NOTE: the stack array is deliberately not reset; sp=0 makes stale entries unreachable.
    always_ff @(posedge clk0) begin
        if (push) stack[sp[AW-1:0]] <= pc_inc;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer: expected per-tick results go through a
// scoreboard queue, plus hand-built wait-state and reset sequences.
module tb_pc_sequencer;
    localparam int PC_W  = 16;
    localparam int SW_W  = 16;
    localparam int DEPTH = 2;
    localparam int DIV   = 4;
    localparam int TICK_BUDGET = 50;

    localparam logic [2:0] C_NEXT = 3'd0, C_JMP = 3'd1, C_BR = 3'd2, C_CALL = 3'd3,
                           C_RET = 3'd4, C_WIN = 3'd5, C_WDL = 3'd6, C_HALT = 3'd7;

    typedef struct {
        logic            rst_before;
        logic [2:0]      cmd;
        logic [PC_W-1:0] target;
        logic            cond;
        logic            dl;
        logic [PC_W-1:0] pc;
        logic [1:0]      sp;
        logic            ovf;
        logic            unf;
        logic            halted;
        logic [SW_W-1:0] rsw;
    } vec_t;

    logic            clk0 = 1'b0;
    logic            reset = 1'b1;
    logic            ent = 1'b1;
    logic [SW_W-1:0] switch = '0;
    logic            dl = 1'b0;
    logic            tick;
    logic [SW_W-1:0] r_switch;
    logic [1:0]      sp;
    logic            ovf, unf, halted;

    pc_sequencer_if #(.PC_W(PC_W)) bus ();

    pc_sequencer #(.PC_W(PC_W), .SW_W(SW_W), .DEPTH(DEPTH), .DIV(DIV)) dut (
        .clk0(clk0), .reset(reset), .bus(bus), .ent(ent), .switch(switch), .dl(dl),
        .tick(tick), .r_switch(r_switch), .sp(sp), .ovf(ovf), .unf(unf), .halted(halted)
    );

    always #5 clk0 = ~clk0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_tick_cyc = 0;
    bit have_last = 1'b0;
    logic [PC_W-1:0] prev_pc = '0;
    vec_t exp_q[$];
    vec_t tbl[$];

    always @(posedge clk0) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic r, logic [2:0] c, logic [PC_W-1:0] t, logic cd, logic d,
                                logic [PC_W-1:0] p, logic [1:0] s, logic o, logic u, logic h,
                                logic [SW_W-1:0] rs);
        vec_t v;
        v.rst_before = r; v.cmd = c; v.target = t; v.cond = cd; v.dl = d;
        v.pc = p; v.sp = s; v.ovf = o; v.unf = u; v.halted = h; v.rsw = rs;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk0);
        reset = 1'b0;
        #1;
        check("rst_pc", 32'(bus.pc), 32'd0);
        check("rst_sp", 32'(sp), 32'd0);
        check("rst_flags", {29'd0, ovf, unf, halted}, 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_r_switch", 32'(r_switch), 32'd0);
        repeat (2) @(negedge clk0);
        reset = 1'b1;
        have_last = 1'b0;
        prev_pc = '0;
    endtask

    // Drive one instruction, wait for the tick that consumes it, compare after the edge.
    task automatic do_tick(input vec_t v);
        int waited;
        vec_t e;
        waited = 0;
        @(negedge clk0);
        bus.cmd = v.cmd;
        bus.target = v.target;
        bus.cond = v.cond;
        dl = v.dl;
        while (tick !== 1'b1 && waited < TICK_BUDGET) begin
            @(negedge clk0);
            waited++;
        end
        if (tick !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL tick_timeout: no tick within %0d cycles", TICK_BUDGET);
            return;
        end
        check("pc_between_ticks", 32'(bus.pc), 32'(prev_pc));
        if (have_last) check("tick_period", cyc - last_tick_cyc, DIV);
        last_tick_cyc = cyc;
        have_last = 1'b1;
        exp_q.push_back(v);
        @(posedge clk0);
        #1;
        e = exp_q.pop_front();
        check("pc", 32'(bus.pc), 32'(e.pc));
        check("sp", 32'(sp), 32'(e.sp));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("unf", 32'(unf), 32'(e.unf));
        check("halted", 32'(halted), 32'(e.halted));
        check("r_switch", 32'(r_switch), 32'(e.rsw));
        check("tick_one_cycle", 32'(tick), 32'd0);
        prev_pc = e.pc;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd = C_NEXT;
        bus.target = '0;
        bus.cond = 1'b0;

        for (int k = 1; k <= 5; k++)
            tbl.push_back(mk(0, C_NEXT, 0, 0, 0, PC_W'(k), 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, C_JMP,  16'h0020, 0, 0, 16'h0020, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, C_BR,   16'h0040, 0, 0, 16'h0021, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, C_BR,   16'h0040, 1, 0, 16'h0040, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, C_CALL, 16'h0010, 0, 0, 16'h0010, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, C_CALL, 16'h0030, 0, 0, 16'h0030, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, C_CALL, 16'h0050, 0, 0, 16'h0030, 2, 1, 0, 1, 0));
        tbl.push_back(mk(0, C_NEXT, 16'h0000, 0, 0, 16'h0030, 2, 1, 0, 1, 0));
        tbl.push_back(mk(0, C_JMP,  16'h0099, 0, 0, 16'h0030, 2, 1, 0, 1, 0));
        tbl.push_back(mk(1, C_RET,  16'h0000, 0, 0, 16'h0000, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, C_JMP,  16'h0007, 0, 0, 16'h0007, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, C_CALL, 16'h0010, 0, 0, 16'h0010, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, C_RET,  16'h0000, 0, 0, 16'h0008, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, C_CALL, 16'h0010, 0, 0, 16'h0010, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, C_CALL, 16'h0030, 0, 0, 16'h0030, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, C_RET,  16'h0000, 0, 0, 16'h0011, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, C_RET,  16'h0000, 0, 0, 16'h0009, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, C_JMP,  16'hFFFF, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, C_NEXT, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, C_HALT, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, C_NEXT, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 0));

        do_reset();
        foreach (tbl[i]) begin
            if (tbl[i].rst_before) do_reset();
            do_tick(tbl[i]);
        end

        // Operator wait: hold without a button, then a 3-cycle press/release.
        do_reset();
        switch = 16'hBEEF;
        repeat (10) do_tick(mk(0, C_WIN, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000));
        @(negedge clk0);
        ent = 1'b0;
        fork
            begin
                repeat (3) @(negedge clk0);
                ent = 1'b1;
            end
        join_none
        do_tick(mk(0, C_WIN, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000));
        do_tick(mk(0, C_WIN, 0, 0, 0, 16'h0001, 0, 0, 0, 0, 16'hBEEF));
        switch = 16'h1234;

        // Display-delay wait: minimum one tick, then held by dl.
        do_tick(mk(0, C_WDL, 0, 0, 0, 16'h0001, 0, 0, 0, 0, 16'hBEEF));
        do_tick(mk(0, C_WDL, 0, 0, 0, 16'h0002, 0, 0, 0, 0, 16'hBEEF));
        repeat (5) do_tick(mk(0, C_WDL, 0, 0, 1, 16'h0002, 0, 0, 0, 0, 16'hBEEF));
        do_tick(mk(0, C_WDL, 0, 0, 0, 16'h0003, 0, 0, 0, 0, 16'hBEEF));

        // Reset while armed must drop the arm flag.
        do_tick(mk(0, C_WDL, 0, 0, 1, 16'h0003, 0, 0, 0, 0, 16'hBEEF));
        do_reset();
        do_tick(mk(0, C_WDL, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000));
        do_tick(mk(0, C_WDL, 0, 0, 0, 16'h0001, 0, 0, 0, 0, 16'h0000));

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
